// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit path.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_DONE,
      GAP
   } tx_ctrl_state_t;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int unsigned count_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with registered read data, occupancy count and flush.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = UART_DATA_W,
   localparam int unsigned CNT_W = count_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;
   logic [CNT_W-1:0]  count_next;

   // Flush wins over any same-cycle push or pop.
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   always_comb begin
      count_next = count;
      if (flush) begin
         count_next = '0;
      end else if (do_push && !do_pop) begin
         count_next = count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_next = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         dout   <= '0;
      end else begin
         count <= count_next;
         full  <= (count_next == CNT_W'(DEPTH));
         empty <= (count_next == '0);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
               dout   <= mem[rd_ptr];
            end
         end
      end
   end

   // Storage needs no reset; occupancy tracking guards every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte queue in front of UART_TX: buffers producer bytes and sequences one
// start/done frame per byte, with an optional idle gap between frames.
module uart_tx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned DATA_W     = UART_DATA_W,
   parameter int unsigned GAP_CYCLES = 0,
   localparam int unsigned CNT_W     = count_w(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_aresetn,
   input  logic              i_wr_valid,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   input  logic              i_flush,
   output logic              o_tx_start,
   output logic [DATA_W-1:0] o_tx_data,
   input  logic              i_tx_done,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_busy,
   output logic              o_overflow
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   tx_ctrl_state_t   state;
   tx_ctrl_state_t   state_next;
   logic [GAP_W-1:0] gap_cnt;
   logic [GAP_W-1:0] gap_next;
   logic             pop_c;
   logic             full;
   logic             empty;

   // Ready is the inverse of the registered full flag, so it reflects the last edge.
   assign o_wr_ready = ~full;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_aresetn),
      .push  (i_wr_valid & o_wr_ready),
      .pop   (pop_c),
      .flush (i_flush),
      .din   (i_wr_data),
      .dout  (o_tx_data),
      .full  (full),
      .empty (empty),
      .count (o_count)
   );

   always_comb begin
      state_next = state;
      gap_next   = gap_cnt;
      pop_c      = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty && !i_flush) begin
               pop_c      = 1'b1;
               state_next = START;
            end
         end
         START: begin
            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_tx_done) begin
               if (GAP_CYCLES > 0) begin
                  state_next = GAP;
                  gap_next   = GAP_LOAD;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               state_next = IDLE;
            end else begin
               gap_next = gap_cnt - GAP_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Start pulse is registered off the START state, landing one edge after the pop.
   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state      <= IDLE;
         gap_cnt    <= '0;
         o_tx_start <= 1'b0;
         o_busy     <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         state      <= state_next;
         gap_cnt    <= gap_next;
         o_tx_start <= (state == START);
         o_busy     <= (state_next != IDLE);
         if (i_wr_valid && !o_wr_ready) begin
            o_overflow <= 1'b1;
         end
      end
   end

endmodule
